// File: rtl/note_playback_scheduler.sv
// Melody playback sequencer sharing the piezo/LED note outputs with keypad echo.
// Optional macro NOTE_SCHED_ABORT_EN: a key press during NOTE_ON/NOTE_OFF aborts playback.
module note_playback_scheduler #(
    parameter int unsigned TICK_DIV  = 2,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] notes,
    input  logic [2:0]  last_index,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_release,
    output logic [3:0]  piezo_out,
    output logic [3:0]  led_out,
    output logic        busy,
    output logic        done,
    output logic        key_accept,
    output logic        key_dropped,
    output logic        aborted,
    output logic [2:0]  note_index_out
);

    localparam int unsigned OnCycles  = ON_TICKS * TICK_DIV;
    localparam int unsigned OffCycles = OFF_TICKS * TICK_DIV;
    localparam int unsigned MaxCycles = (OnCycles > OffCycles) ? OnCycles : OffCycles;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] OnLast  = CntW'(OnCycles - 1);
    localparam logic [CntW-1:0] OffLast = CntW'(OffCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StNoteOn,
        StNoteOff,
        StDone,
        StKeyEcho
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [23:0]     notes_q, notes_d;
    logic [2:0]      last_q, last_d;
    logic [3:0]      key_q, key_d;
    logic            key_accept_q, key_accept_d;
    logic            key_dropped_q, key_dropped_d;
    logic [23:0]     notes_packed;
    logic            unused_notes_msb;

    // Only the low three bits of each 4-bit slot carry a note.
    always_comb begin
        notes_packed = '0;
        for (int i = 0; i < 8; i++) begin
            notes_packed[3*i +: 3] = notes[4*i +: 3];
        end
    end
    assign unused_notes_msb = ^{notes[31], notes[27], notes[23], notes[19],
                                notes[15], notes[11], notes[7], notes[3]};

`ifdef NOTE_SCHED_ABORT_EN
    logic aborted_q, aborted_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        idx_d         = idx_q;
        notes_d       = notes_q;
        last_d        = last_q;
        key_d         = key_q;
        key_accept_d  = 1'b0;
        key_dropped_d = 1'b0;
`ifdef NOTE_SCHED_ABORT_EN
        aborted_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (start) begin
                    notes_d       = notes_packed;
                    last_d        = last_index;
                    state_d       = StLoad;
                    key_dropped_d = key_valid;
                end else if (key_valid) begin
                    key_d        = key_code;
                    key_accept_d = 1'b1;
                    state_d      = StKeyEcho;
                end
            end
            StLoad: begin
                idx_d         = '0;
                state_d       = StNoteOn;
                key_dropped_d = key_valid;
            end
            StNoteOn: begin
                if (cnt_q == OnLast) begin
                    state_d = StNoteOff;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StNoteOff: begin
                if (cnt_q == OffLast) begin
                    if (idx_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StNoteOn;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                idx_d         = '0;
                state_d       = StIdle;
                key_dropped_d = key_valid;
            end
            StKeyEcho: begin
                if (key_release) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Key presses while a note is timed either abort playback or are refused.
        if ((state_q == StNoteOn || state_q == StNoteOff) && key_valid) begin
`ifdef NOTE_SCHED_ABORT_EN
            state_d      = StKeyEcho;
            cnt_d        = '0;
            idx_d        = '0;
            key_d        = key_code;
            key_accept_d = 1'b1;
            aborted_d    = 1'b1;
`else
            key_dropped_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            idx_q         <= '0;
            notes_q       <= '0;
            last_q        <= '0;
            key_q         <= '0;
            key_accept_q  <= 1'b0;
            key_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            notes_q       <= notes_d;
            last_q        <= last_d;
            key_q         <= key_d;
            key_accept_q  <= key_accept_d;
            key_dropped_q <= key_dropped_d;
        end
    end

`ifdef NOTE_SCHED_ABORT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end
    assign aborted = aborted_q;
`else
    assign aborted = 1'b0;
`endif

    always_comb begin
        piezo_out = '0;
        unique case (state_q)
            StNoteOn:  piezo_out = {1'b0, notes_q[3*int'(idx_q) +: 3]};
            StKeyEcho: piezo_out = key_q;
            default:   piezo_out = '0;
        endcase
    end

    assign led_out        = piezo_out;
    assign busy           = (state_q == StLoad) || (state_q == StNoteOn) ||
                            (state_q == StNoteOff) || (state_q == StDone);
    assign done           = (state_q == StDone);
    assign key_accept     = key_accept_q;
    assign key_dropped    = key_dropped_q;
    assign note_index_out = busy ? idx_q : 3'd0;

endmodule

// File: tb/tb_note_playback_scheduler.sv
// Scoreboard bench: stimulus pushes the expected per-cycle output vector, a negedge monitor
// pops and compares it against the scheduler outputs.
module tb_note_playback_scheduler;

    localparam int OnCyc  = 4;
    localparam int OffCyc = 4;

    logic        clk = 1'b0;
    logic        reset, start, key_valid, key_release;
    logic [31:0] notes;
    logic [2:0]  last_index;
    logic [3:0]  key_code;
    logic [3:0]  piezo_out, led_out;
    logic        busy, done, key_accept, key_dropped, aborted;
    logic [2:0]  note_index_out;

    note_playback_scheduler #(.TICK_DIV(2), .ON_TICKS(2), .OFF_TICKS(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .notes          (notes),
        .last_index     (last_index),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_release    (key_release),
        .piezo_out      (piezo_out),
        .led_out        (led_out),
        .busy           (busy),
        .done           (done),
        .key_accept     (key_accept),
        .key_dropped    (key_dropped),
        .aborted        (aborted),
        .note_index_out (note_index_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] p;
        logic       chk_p;
        logic       busy;
        logic       done;
        logic       acc;
        logic       drop;
        logic       abrt;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   n, key_at, start_at;
    bit   drop_next;

    function automatic exp_t mk(input logic [3:0] p, input logic b, input logic d,
                                input logic a, input logic dr, input logic ab,
                                input logic [2:0] i);
        exp_t e;
        e.p = p; e.chk_p = 1'b1; e.busy = b; e.done = d; e.acc = a;
        e.drop = dr; e.abrt = ab; e.idx = i;
        return e;
    endfunction

    always @(negedge clk) begin
        cycle++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ((e.chk_p && piezo_out !== e.p) || led_out !== piezo_out || busy !== e.busy ||
                done !== e.done || key_accept !== e.acc || key_dropped !== e.drop ||
                aborted !== e.abrt || note_index_out !== e.idx) begin
                failures++;
                $display("FAIL cycle%0d got piezo=%h led=%h busy=%b done=%b acc=%b drop=%b abrt=%b idx=%0d want piezo=%h(chk=%b) busy=%b done=%b acc=%b drop=%b abrt=%b idx=%0d",
                         cycle, piezo_out, led_out, busy, done, key_accept, key_dropped,
                         aborted, note_index_out, e.p, e.chk_p, e.busy, e.done, e.acc,
                         e.drop, e.abrt, e.idx);
            end
        end
    end

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [3:0] p, input logic b, input logic d, input logic [2:0] i);
        key_valid = (n == key_at);
        key_code  = 4'h9;
        start     = (n == start_at);
        cyc(mk(p, b, d, 1'b0, drop_next, 1'b0, i));
        drop_next = (n == key_at);
        key_valid = 1'b0;
        start     = 1'b0;
        n++;
    endtask

    task automatic play(input logic [31:0] nv, input logic [2:0] li, input int k_at,
                        input int s_at, input bit key_with_start);
        key_at     = k_at;
        start_at   = s_at;
        n          = 1;
        notes      = nv;
        last_index = li;
        start      = 1'b1;
        key_valid  = key_with_start;
        key_code   = 4'h9;
        cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));
        start      = 1'b0;
        key_valid  = 1'b0;
        notes      = ~nv;
        last_index = ~li;
        drop_next  = key_with_start;
        tick(4'h0, 1, 0, 3'd0);
        for (int i = 0; i <= int'(li); i++) begin
            repeat (OnCyc) tick({1'b0, nv[4*i +: 3]}, 1, 0, 3'(i));
            repeat (OffCyc) tick(4'h0, 1, 0, 3'(i));
        end
        tick(4'h0, 1, 1, li);
        tick(4'h0, 0, 0, 3'd0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_release = 1'b0;
        notes = 32'h0; last_index = 3'd0; key_code = 4'h0;
        key_at = -1; start_at = -1; drop_next = 1'b0; n = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));

        // Three-note melody 1,3,5 with 4/4 timing; busy spans 26 cycles.
        play(32'h0000_0531, 3'd2, -1, -1, 1'b0);
        // Bit 3 of each slot is masked, single note.
        play(32'hFFFF_FFFF, 3'd0, -1, -1, 1'b0);

        // Keypad echo; a second press while echoing is ignored.
        key_valid = 1'b1; key_code = 4'h6;
        cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));
        key_valid = 1'b0; key_code = 4'h0;
        cyc(mk(4'h6, 0, 0, 1, 0, 0, 3'd0));
        key_valid = 1'b1; key_code = 4'h3;
        cyc(mk(4'h6, 0, 0, 0, 0, 0, 3'd0));
        key_valid = 1'b0;
        cyc(mk(4'h6, 0, 0, 0, 0, 0, 3'd0));
        key_release = 1'b1;
        e = mk(4'h0, 0, 0, 0, 0, 0, 3'd0);
        e.chk_p = 1'b0;
        cyc(e);
        key_release = 1'b0;
        cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));
        cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));

`ifndef NOTE_SCHED_ABORT_EN
        // Key in the second NOTE_ON is dropped; a stray start there is ignored.
        play(32'h0000_0531, 3'd2, 11, 13, 1'b0);
`endif
        // start and key_valid together: start wins, key dropped.
        play(32'h0000_0246, 3'd1, -1, -1, 1'b1);

        // Reset during NOTE_ON of slot 1.
        key_at = -1; start_at = -1; drop_next = 1'b0; n = 1;
        notes = 32'h0000_0531; last_index = 3'd2; start = 1'b1;
        cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));
        start = 1'b0;
        tick(4'h0, 1, 0, 3'd0);
        repeat (OnCyc) tick(4'h1, 1, 0, 3'd0);
        repeat (OffCyc) tick(4'h0, 1, 0, 3'd0);
        tick(4'h3, 1, 0, 3'd1);
        reset = 1'b1;
        cyc(mk(4'h3, 1, 0, 0, 0, 0, 3'd1));
        reset = 1'b0;
        repeat (10) cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));
        play(32'h0000_0531, 3'd2, -1, -1, 1'b0);

`ifdef NOTE_SCHED_ABORT_EN
        // Key during NOTE_OFF of slot 0 aborts into echo of code 2.
        notes = 32'h0000_0531; last_index = 3'd2; start = 1'b1;
        cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));
        start = 1'b0;
        cyc(mk(4'h0, 1, 0, 0, 0, 0, 3'd0));
        repeat (OnCyc) cyc(mk(4'h1, 1, 0, 0, 0, 0, 3'd0));
        key_valid = 1'b1; key_code = 4'h2;
        cyc(mk(4'h0, 1, 0, 0, 0, 0, 3'd0));
        key_valid = 1'b0;
        cyc(mk(4'h2, 0, 0, 1, 0, 1, 3'd0));
        cyc(mk(4'h2, 0, 0, 0, 0, 0, 3'd0));
        key_release = 1'b1;
        e = mk(4'h0, 0, 0, 0, 0, 0, 3'd0);
        e.chk_p = 1'b0;
        cyc(e);
        key_release = 1'b0;
        repeat (3) cyc(mk(4'h0, 0, 0, 0, 0, 0, 3'd0));
`endif

        #20;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
